pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-width IF/ID latch.
- One generic inter-stage register for any pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds valid/ready flow control, a one-entry skid buffer so in_ready is a pure register output, flush with bubble injection, and saturating stall/flush/bubble event counters for hazard-unit debug.
- The payload is an opaque DATA_W bus that the instantiating stage packs (e.g. instr, PC, PC+4).

Parameters:
- DATA_W, 96: payload width in bits.
- BUBBLE_VAL, {DATA_W{1'b0}}: value driven on out_data when the stage is empty or flushed (NOP encoding).
- CNT_W, 16: width of each event counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; driven directly from a flop.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main entry holds a valid payload.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main entry payload, or BUBBLE_VAL when out_valid=0.
- hold  in  1  hazard-unit stall; freezes the output side.
- flush  in  1  hazard-unit clear; discards all contents.
- occupancy  out  2  number of valid entries (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and no output transfer.
- flush_cnt  out  CNT_W  flush events that discarded at least one valid entry.
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1.

Behaviour:
- Reset (rst=0 at posedge):
  - main and skid entries invalid; both data registers = BUBBLE_VAL.
  - in_ready=1, out_valid=0, occupancy=0, all counters=0.
  - All inputs ignored while rst=0.
- Transfer definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready & ~hold.
- State machine, encoded by valid bits:
  - EMPTY (main=0, skid=0):
    - in_fire → FULL; main loads in_data.
  - FULL (main=1, skid=0):
    - in_fire & out_fire → FULL; main loads in_data.
    - in_fire & ~out_fire → SKID; skid loads in_data; in_ready←0.
    - ~in_fire & out_fire → EMPTY.
    - otherwise stay.
  - SKID (main=1, skid=1), in_ready=0:
    - out_fire → FULL; main←skid; in_ready←1.
    - otherwise stay.
- in_ready is registered. It is 0 exactly when the next state is SKID.
- Latency: 1 cycle from in_fire to out_valid. Full throughput (1 transfer/cycle) when out_ready=1 and hold=0.
- Hold:
  - Blocks out_fire only. Main and out_data stay frozen.
  - Upstream may still fill the skid entry.
- Flush:
  - Highest priority after reset.
  - Next state is EMPTY: both valid bits cleared, data = BUBBLE_VAL, in_ready←1.
  - A coincident in_fire payload is dropped.
  - A coincident out_fire still counts as a transfer at the downstream stage. This stage just empties.
- Simultaneous flush & hold: flush wins.
- out_data = BUBBLE_VAL whenever out_valid=0. No stale data is ever exposed.
- Counters:
  - Each increments by 1 per qualifying cycle.
  - Saturate at 2^CNT_W−1; no wrap.
  - Reset only by rst.
  - flush_cnt counts a flush cycle only if occupancy≠0.
- occupancy = main_valid + skid_valid, registered alongside the state.
- Invariant: a payload accepted via in_fire exits exactly once via out_fire, in order, unless flushed. No duplication or reordering is allowed.

Decomposition:
- Shared package pipe_pkg holds:
  - occupancy constants OCC_EMPTY=0, OCC_FULL=1, OCC_SKID=2.
  - the default NOP encoding 32'h0000_0013 for instruction-carrying stages.
  - per-boundary DATA_W constants: IFID_W=96, IDEX_W, etc.
- One sub-module: sat_counter (CNT_W, inc → saturating count), instantiated three times.
- All datapath and FSM logic stays in pipe_stage_reg.

Test Plan:
- Streaming:
  - Stimulus: reset, then in_valid=1 with in_data=1,2,3,… for 10 cycles; out_ready=1, hold=0.
  - Response: out_data=1..10 one cycle later each; in_ready stays 1; occupancy ≤1; stall_cnt=0.
- Backpressure into skid:
  - Stimulus: push A, B with out_ready=0.
  - Response: occupancy=2; in_ready=0 the cycle after B is accepted; C is held upstream.
  - Then raise out_ready: order A, B, C on out_data; stall_cnt = number of blocked cycles.
- Hold:
  - Stimulus: main=X; hold=1 for 3 cycles with out_ready=1.
  - Response: out_data=X, out_valid=1 throughout; stall_cnt+=3; X emitted on the first cycle after hold drops.
- Flush with skid full:
  - Stimulus: occupancy=2; assert flush together with in_valid=1 and in_data=D.
  - Response: next cycle out_valid=0, out_data=BUBBLE_VAL, in_ready=1, occupancy=0; D never appears; flush_cnt=1.
  - A flush while EMPTY leaves flush_cnt unchanged.
- Reset mid-operation:
  - Stimulus: occupancy=2; rst=0 for 1 cycle with in_valid=1.
  - Response: all outputs return to reset values; nothing is accepted.
- Saturation:
  - Stimulus: CNT_W=4; out_valid=0 and out_ready=1 for 20 cycles.
  - Response: bubble_cnt stops at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the generic inter-stage pipeline register.
//   - occupancy constants (also used as the state encoding)
//   - default NOP encoding for instruction-carrying stages
//   - payload widths for each pipeline boundary
package pipe_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_FULL  = 2'd1;
    localparam logic [1:0] OCC_SKID  = 2'd2;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Payload widths per boundary
    localparam int IFID_W  = 96;   // instr, pc, pc+4
    localparam int IDEX_W  = 160;  // pc, rs1 val, rs2 val, imm, ctrl
    localparam int EXMEM_W = 112;  // alu result, store data, rd/ctrl
    localparam int MEMWB_W = 80;   // wb data, pc+4 low, rd/ctrl

    // The state value equals the number of valid entries, so the state
    // register doubles as the registered occupancy output.
    typedef enum logic [1:0] {
        ST_EMPTY = OCC_EMPTY,
        ST_FULL  = OCC_FULL,
        ST_SKID  = OCC_SKID
    } stage_state_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: event counter that increments by one per cycle with inc=1
// and sticks at all-ones instead of wrapping.
//   clk   in   clock
//   rst   in   synchronous active-low reset, clears the count
//   inc   in   count this cycle
//   count out  current count (CNT_W bits)
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage register with valid/ready handshake,
// one-entry skid buffer (so in_ready comes straight from a flop), flush with
// bubble injection and saturating stall/flush/bubble debug counters.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-low reset
//   in_valid    in   upstream payload valid
//   in_ready    out  stage can accept (registered)
//   in_data     in   upstream payload
//   out_valid   out  main entry holds a valid payload
//   out_ready   in   downstream accepts
//   out_data    out  main entry payload, BUBBLE_VAL when out_valid=0
//   hold        in   stall from hazard unit, freezes output side
//   flush       in   clear from hazard unit, discards all contents
//   occupancy   out  number of valid entries (0..2)
//   stall_cnt   out  cycles with out_valid=1 and no output transfer
//   flush_cnt   out  flushes that discarded at least one entry
//   bubble_cnt  out  cycles with out_valid=0 and out_ready=1
//
// State  | meaning
// -------+-------------------------------------------------------
// EMPTY  | main and skid invalid, in_ready=1
// FULL   | main valid, skid invalid, in_ready=1
// SKID   | main and skid valid, in_ready=0
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 96,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    stage_state_t      state, state_n;
    logic [DATA_W-1:0] main_data, main_n;
    logic [DATA_W-1:0] skid_data, skid_n;
    logic              in_ready_n;
    logic              in_fire, out_fire;

    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready & ~hold;

    // main_data is forced to BUBBLE_VAL whenever the main entry goes
    // invalid, so out_data can come straight from the register.
    assign out_data  = main_data;
    assign occupancy = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_EMPTY;
            main_data <= BUBBLE_VAL;
            skid_data <= BUBBLE_VAL;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_n;
            main_data <= main_n;
            skid_data <= skid_n;
            in_ready  <= in_ready_n;
        end
    end

    always_comb begin
        state_n = state;
        main_n  = main_data;
        skid_n  = skid_data;

        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_n = ST_FULL;
                    main_n  = in_data;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    main_n = in_data;
                end else if (in_fire) begin
                    state_n = ST_SKID;
                    skid_n  = in_data;
                end else if (out_fire) begin
                    state_n = ST_EMPTY;
                    main_n  = BUBBLE_VAL;
                end
            end
            ST_SKID: begin
                // in_ready is 0 here, so nothing new can arrive
                if (out_fire) begin
                    state_n = ST_FULL;
                    main_n  = skid_data;
                    skid_n  = BUBBLE_VAL;
                end
            end
            default: begin
                state_n = ST_EMPTY;
                main_n  = BUBBLE_VAL;
                skid_n  = BUBBLE_VAL;
            end
        endcase

        // Flush overrides everything (including hold); a coincident
        // input payload is simply dropped.
        if (flush) begin
            state_n = ST_EMPTY;
            main_n  = BUBBLE_VAL;
            skid_n  = BUBBLE_VAL;
        end

        in_ready_n = (state_n != ST_SKID);
    end

    logic stall_inc, flush_inc, bubble_inc;

    assign stall_inc  = out_valid & ~out_fire;
    assign flush_inc  = flush & (state != ST_EMPTY);
    assign bubble_inc = ~out_valid & out_ready;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed test of pipe_stage_reg. Main instance uses a
// 32-bit payload with the NOP bubble; a second instance with 4-bit counters
// checks counter saturation.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int          DW  = 32;
    localparam logic [31:0] BUB = NOP_INSTR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, out_ready, hold, flush;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt, flush_cnt, bubble_cnt;

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .hold       (hold),
        .flush      (flush),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .bubble_cnt (bubble_cnt)
    );

    logic       s_rst, s_out_ready;
    logic       s_in_ready, s_out_valid;
    logic [7:0] s_out_data;
    logic [1:0] s_occupancy;
    logic [3:0] s_stall_cnt, s_flush_cnt, s_bubble_cnt;

    pipe_stage_reg #(.DATA_W(8), .BUBBLE_VAL(8'h00), .CNT_W(4)) dut_sat (
        .clk        (clk),
        .rst        (s_rst),
        .in_valid   (1'b0),
        .in_ready   (s_in_ready),
        .in_data    (8'h00),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_data   (s_out_data),
        .hold       (1'b0),
        .flush      (1'b0),
        .occupancy  (s_occupancy),
        .stall_cnt  (s_stall_cnt),
        .flush_cnt  (s_flush_cnt),
        .bubble_cnt (s_bubble_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".in_ready"},   64'(in_ready),   64'd1);
        chk({tag, ".out_valid"},  64'(out_valid),  64'd0);
        chk({tag, ".out_data"},   64'(out_data),   64'(BUB));
        chk({tag, ".occupancy"},  64'(occupancy),  64'd0);
        chk({tag, ".stall_cnt"},  64'(stall_cnt),  64'd0);
        chk({tag, ".flush_cnt"},  64'(flush_cnt),  64'd0);
        chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'd0);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        out_ready = 1'b0; hold = 1'b0; flush = 1'b0;
        s_rst = 1'b0; s_out_ready = 1'b0;
        step(); step();
        chk_reset_state("reset");

        // Streaming: 1..10, one cycle latency, full throughput
        rst = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            step();
            chk($sformatf("stream.data%0d", i), 64'(out_data), 64'(i));
            chk($sformatf("stream.rdy%0d", i), 64'(in_ready), 64'd1);
            chk($sformatf("stream.occ%0d", i), 64'(occupancy), 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream.drain_valid", 64'(out_valid), 64'd0);
        chk("stream.drain_data",  64'(out_data),  64'(BUB));
        chk("stream.stall_cnt",   64'(stall_cnt), 64'd0);
        chk("stream.bubble_cnt",  64'(bubble_cnt), 64'd1);

        // Backpressure into skid: A, B then C held upstream
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA;
        step();
        chk("bp.A_occ", 64'(occupancy), 64'd1);
        in_data = 32'hB;
        step();
        chk("bp.B_occ",   64'(occupancy), 64'd2);
        chk("bp.B_rdy",   64'(in_ready),  64'd0);
        chk("bp.B_data",  64'(out_data),  64'hA);
        in_data = 32'hC;
        step();
        chk("bp.C_blocked_occ",  64'(occupancy), 64'd2);
        chk("bp.C_blocked_data", 64'(out_data),  64'hA);
        out_ready = 1'b1;
        step();
        chk("bp.out_B",     64'(out_data), 64'hB);
        chk("bp.rdy_again", 64'(in_ready), 64'd1);
        chk("bp.occ_B",     64'(occupancy), 64'd1);
        step();
        chk("bp.out_C", 64'(out_data), 64'hC);
        in_valid = 1'b0;
        step();
        chk("bp.empty_occ", 64'(occupancy), 64'd0);
        chk("bp.stall_cnt", 64'(stall_cnt), 64'd2);

        // Hold: X frozen for 3 cycles, then emitted
        in_valid = 1'b1; in_data = 32'h55;
        step();
        in_valid = 1'b0; hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold.valid%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("hold.data%0d", i),  64'(out_data),  64'h55);
        end
        chk("hold.stall_cnt", 64'(stall_cnt), 64'd5);
        hold = 1'b0;
        chk("hold.release_data", 64'(out_data), 64'h55);
        step();
        chk("hold.emitted_valid", 64'(out_valid), 64'd0);
        chk("hold.stall_after",   64'(stall_cnt), 64'd5);
        chk("hold.bubble_cnt",    64'(bubble_cnt), 64'd2);

        // Flush with skid full plus coincident input D
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11;
        step();
        in_data = 32'h22;
        step();
        chk("flush.pre_occ", 64'(occupancy), 64'd2);
        flush = 1'b1; in_data = 32'hDD;
        step();
        chk("flush.valid",     64'(out_valid), 64'd0);
        chk("flush.data",      64'(out_data),  64'(BUB));
        chk("flush.rdy",       64'(in_ready),  64'd1);
        chk("flush.occ",       64'(occupancy), 64'd0);
        chk("flush.flush_cnt", 64'(flush_cnt), 64'd1);
        chk("flush.stall_cnt", 64'(stall_cnt), 64'd7);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("flush.no_D_valid", 64'(out_valid), 64'd0);
        chk("flush.no_D_data",  64'(out_data),  64'(BUB));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush.empty_cnt",  64'(flush_cnt),  64'd1);
        chk("flush.bubble_cnt", 64'(bubble_cnt), 64'd4);

        // Reset mid-operation with skid full and input presented
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h31;
        step();
        in_data = 32'h32;
        step();
        chk("rstmid.pre_occ", 64'(occupancy), 64'd2);
        rst = 1'b0; in_data = 32'h77;
        step();
        chk_reset_state("rstmid");
        rst = 1'b1; in_valid = 1'b0;
        step();
        chk("rstmid.nothing_valid", 64'(out_valid), 64'd0);
        chk("rstmid.nothing_occ",   64'(occupancy), 64'd0);

        // Saturation on 4-bit counters
        s_rst = 1'b1; s_out_ready = 1'b1;
        for (int i = 0; i < 14; i++) step();
        chk("sat.bubble14", 64'(s_bubble_cnt), 64'd14);
        for (int i = 0; i < 6; i++) step();
        chk("sat.bubble20", 64'(s_bubble_cnt), 64'd15);
        chk("sat.stall",    64'(s_stall_cnt),  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
